// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: state encoding,
// watchdog width and a constant-friendly ceiling log2.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int WDOG_W = 16;

    // Ceiling log2, never less than 1 so a two-master pointer is still one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: the first requester found scanning
// upward from the slot after the last winner, wrapping modulo NM.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int NM = 4,
    localparam int PW = clog2(NM)
) (
    input  logic [NM-1:0] i_req,
    input  logic [PW-1:0] i_last,
    output logic [NM-1:0] o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    logic [PW-1:0] w_cand;

    // Walk the NM candidates in priority order and latch onto the first requester.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NM; k++) begin
            w_cand = PW'((int'(i_last) + k) % NM);
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone arbiter sharing one slave port among NM masters. The grant is
// held for the whole CYC so block and RMW cycles stay atomic; responses go to
// the owner only; a watchdog aborts transfers the slave never terminates.
//
// Handshake: a beat completes in any cycle where S_STB_O is high and the
// slave raises one of S_ACK_I / S_ERR_I / S_RTY_I; the owner releases the bus
// by dropping its CYC, which is sampled at the clock edge.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int NM      = 4,
    parameter  int AW      = 8,
    parameter  int DW      = 32,
    parameter  int TIMEOUT = 255,
    localparam int PW      = clog2(NM),
    localparam int SW      = DW / 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic [NM-1:0]    M_CYC_I,
    input  logic [NM-1:0]    M_STB_I,
    input  logic [NM-1:0]    M_WE_I,
    input  logic [NM*AW-1:0] M_ADR_I,
    input  logic [NM*DW-1:0] M_DAT_I,
    input  logic [NM*SW-1:0] M_SEL_I,
    output logic [DW-1:0]    M_DAT_O,
    output logic [NM-1:0]    M_ACK_O,
    output logic [NM-1:0]    M_ERR_O,
    output logic [NM-1:0]    M_RTY_O,
    output logic             S_CYC_O,
    output logic             S_STB_O,
    output logic             S_WE_O,
    output logic [AW-1:0]    S_ADR_O,
    output logic [DW-1:0]    S_DAT_O,
    output logic [SW-1:0]    S_SEL_O,
    input  logic [DW-1:0]    S_DAT_I,
    input  logic             S_ACK_I,
    input  logic             S_ERR_I,
    input  logic             S_RTY_I,
    output logic [NM-1:0]    GNT_O,
    output logic             TMO_O,
    output logic [1:0]       o_dbg_state
);

    arb_state_t          r_state, w_state_nxt;
    logic [NM-1:0]       r_gnt, w_gnt_nxt;
    logic [PW-1:0]       r_owner, w_owner_nxt;
    logic [PW-1:0]       r_last, w_last_nxt;
    logic [WDOG_W-1:0]   r_wdog, w_wdog_nxt;
    logic                r_tmo, w_tmo_nxt;

    logic [NM-1:0]       w_pick_gnt;
    logic [PW-1:0]       w_pick_idx;
    logic                w_pick_valid;

    logic                w_own_cyc;
    logic                w_s_stb;
    logic                w_term;
    logic                w_wdog_hit;

    wb_rr_pick #(.NM(NM)) u_pick (
        .i_req   (M_CYC_I),
        .i_last  (r_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_own_cyc  = M_CYC_I[r_owner];
    assign w_s_stb    = (r_state == ST_OWN) && w_own_cyc && M_STB_I[r_owner];
    assign w_term     = S_ACK_I | S_ERR_I | S_RTY_I;
    assign w_wdog_hit = (r_wdog == WDOG_W'(TIMEOUT - 1));

    assign GNT_O       = r_gnt;
    assign TMO_O       = r_tmo;
    assign o_dbg_state = r_state;

    // State, grant, pointer and watchdog registers; reset makes master 0 win first.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= PW'(NM - 1);
            r_wdog  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_wdog  <= w_wdog_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, hold until owner drops CYC, abort on watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_wdog_nxt  = '0;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_valid) begin
                    w_state_nxt = ST_OWN;
                    w_gnt_nxt   = w_pick_gnt;
                    w_owner_nxt = w_pick_idx;
                end
            end
            ST_OWN: begin
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end else if (w_s_stb && !w_term) begin
                    if (w_wdog_hit) begin
                        w_state_nxt = ST_ABORT;
                        w_tmo_nxt   = 1'b1;
                    end else begin
                        w_wdog_nxt = r_wdog + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // Bus muxing: slave sees the owner only in OWN; responses are routed to the owner bit.
    always_comb begin
        S_CYC_O = 1'b0;
        S_STB_O = 1'b0;
        S_WE_O  = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        S_SEL_O = '0;
        M_DAT_O = '0;
        M_ACK_O = '0;
        M_ERR_O = '0;
        M_RTY_O = '0;
        if (r_state == ST_OWN) begin
            S_CYC_O          = w_own_cyc;
            S_STB_O          = w_s_stb;
            S_WE_O           = M_WE_I[r_owner];
            S_ADR_O          = M_ADR_I[int'(r_owner)*AW +: AW];
            S_DAT_O          = M_DAT_I[int'(r_owner)*DW +: DW];
            S_SEL_O          = M_SEL_I[int'(r_owner)*SW +: SW];
            M_DAT_O          = S_DAT_I;
            M_ACK_O[r_owner] = S_ACK_I & w_s_stb;
            M_ERR_O[r_owner] = S_ERR_I & w_s_stb;
            M_RTY_O[r_owner] = S_RTY_I & w_s_stb;
        end else if (r_state == ST_ABORT) begin
            // r_tmo is high only in the first ABORT cycle.
            M_ERR_O[r_owner] = r_tmo;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios followed by randomized masters
// and slave, all compared each cycle against a transaction-level model.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic CLK_I = 1'b0;
  logic RST_I;
  always #5 CLK_I = ~CLK_I;

  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic [DW-1:0]    s_dat;
  logic             s_ack, s_err, s_rty;

  logic [DW-1:0]    M_DAT_O;
  logic [NM-1:0]    M_ACK_O, M_ERR_O, M_RTY_O, GNT_O;
  logic             S_CYC_O, S_STB_O, S_WE_O, TMO_O;
  logic [AW-1:0]    S_ADR_O;
  logic [DW-1:0]    S_DAT_O;
  logic [SW-1:0]    S_SEL_O;
  logic [1:0]       dbg_state;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_WE_I(m_we),
    .M_ADR_I(m_adr), .M_DAT_I(m_dat), .M_SEL_I(m_sel),
    .M_DAT_O(M_DAT_O), .M_ACK_O(M_ACK_O), .M_ERR_O(M_ERR_O), .M_RTY_O(M_RTY_O),
    .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O),
    .S_DAT_I(s_dat), .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty),
    .GNT_O(GNT_O), .TMO_O(TMO_O), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [NM-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner < 0 means the bus is free; waited counts unanswered strobe cycles.
  int mdl_owner, mdl_last, mdl_waited;
  bit mdl_abort, mdl_abort_first;

  logic [NM-1:0] e_ack, e_err, e_rty, e_gnt;
  logic          e_scyc, e_sstb, e_swe, e_tmo;
  logic [AW-1:0] e_sadr;
  logic [DW-1:0] e_sdat, e_mdat;
  logic [SW-1:0] e_ssel;

  function automatic bit bit_of(input logic [NM-1:0] v, input int i);
    return ((v >> i) & NM'(1)) != '0;
  endfunction

  task automatic model_reset();
    mdl_owner = -1; mdl_last = NM - 1; mdl_waited = 0;
    mdl_abort = 0; mdl_abort_first = 0;
    e_ack = '0; e_err = '0; e_rty = '0;
  endtask

  task automatic model_eval();
    logic [NM-1:0] one;
    int o;
    e_ack = '0; e_err = '0; e_rty = '0; e_gnt = '0;
    e_scyc = 0; e_sstb = 0; e_swe = 0; e_tmo = 0;
    e_sadr = '0; e_sdat = '0; e_ssel = '0; e_mdat = '0;
    if (mdl_owner >= 0) begin
      o = mdl_owner;
      one = NM'(1) << o;
      e_gnt = one;
      if (!mdl_abort) begin
        e_scyc = bit_of(m_cyc, o);
        e_sstb = bit_of(m_cyc, o) && bit_of(m_stb, o);
        e_swe  = bit_of(m_we, o);
        e_sadr = m_adr[o*AW +: AW];
        e_sdat = m_dat[o*DW +: DW];
        e_ssel = m_sel[o*SW +: SW];
        e_mdat = s_dat;
        if (e_sstb && s_ack) e_ack = one;
        if (e_sstb && s_err) e_err = one;
        if (e_sstb && s_rty) e_rty = one;
      end else begin
        if (mdl_abort_first) e_err = one;
        e_tmo = mdl_abort_first;
      end
    end
  endtask

  task automatic model_step();
    int c;
    int pick;
    if (mdl_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= NM; k++) begin
        c = (mdl_last + k) % NM;
        if (pick < 0 && bit_of(m_cyc, c)) pick = c;
      end
      if (pick >= 0) begin
        mdl_owner = pick; mdl_waited = 0; mdl_abort = 0;
      end
    end else if (mdl_abort) begin
      mdl_abort_first = 0;
      if (!bit_of(m_cyc, mdl_owner)) begin
        mdl_last = mdl_owner; mdl_owner = -1; mdl_abort = 0;
      end
    end else if (!bit_of(m_cyc, mdl_owner)) begin
      mdl_last = mdl_owner; mdl_owner = -1; mdl_waited = 0;
    end else if (e_sstb && !(s_ack || s_err || s_rty)) begin
      mdl_waited++;
      if (mdl_waited >= TO) begin
        mdl_abort = 1; mdl_abort_first = 1; mdl_waited = 0;
      end
    end else begin
      mdl_waited = 0;
    end
  endtask

  // One bus cycle: inputs are already driven (just after a falling edge).
  task automatic run_cycle();
    #1;
    model_eval();
    check_val("s_cyc", S_CYC_O, e_scyc);
    check_val("s_stb", S_STB_O, e_sstb);
    check_val("s_we",  S_WE_O,  e_swe);
    check_val("s_adr", S_ADR_O, e_sadr);
    check_val("s_dat", S_DAT_O, e_sdat);
    check_val("s_sel", S_SEL_O, e_ssel);
    check_val("m_dat", M_DAT_O, e_mdat);
    check_val("m_ack", M_ACK_O, e_ack);
    check_val("m_err", M_ERR_O, e_err);
    check_val("m_rty", M_RTY_O, e_rty);
    check_val("gnt",   GNT_O,   e_gnt);
    check_val("tmo",   TMO_O,   e_tmo);
    model_step();
    @(negedge CLK_I);
  endtask

  // ---------------- driver tasks ----------------
  int beats[NM];
  int hang;

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat = '0; s_ack = 0; s_err = 0; s_rty = 0;
    for (int i = 0; i < NM; i++) beats[i] = 0;
    hang = 0;
  endtask

  task automatic do_reset();
    RST_I = 1'b1;
    clear_inputs();
    @(negedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;
    model_reset();
  endtask

  task automatic new_beat(input int i);
    m_we[i] = 1'($urandom_range(0, 1));
    m_adr[i*AW +: AW] = AW'($urandom);
    m_dat[i*DW +: DW] = $urandom;
    m_sel[i*SW +: SW] = SW'($urandom_range(1, 15));
  endtask

  // Random masters react to the responses the model predicted for the last cycle.
  task automatic masters_step();
    for (int i = 0; i < NM; i++) begin
      if (m_cyc[i]) begin
        if (e_err[i] || e_rty[i]) begin
          m_cyc[i] = 0; m_stb[i] = 0;
        end else if (e_ack[i]) begin
          beats[i]--;
          if (beats[i] <= 0) begin
            m_cyc[i] = 0; m_stb[i] = 0;
          end else begin
            new_beat(i);
            m_stb[i] = ($urandom_range(0, 3) != 0);
          end
        end else if (!m_stb[i]) begin
          m_stb[i] = ($urandom_range(0, 1) == 1);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        m_cyc[i] = 1; m_stb[i] = 1;
        beats[i] = int'($urandom_range(1, 4));
        new_beat(i);
      end
    end
  endtask

  task automatic slave_step();
    int r;
    s_dat = $urandom;
    if (hang > 0) begin
      hang--;
      s_ack = 0; s_err = 0; s_rty = 0;
    end else begin
      r = int'($urandom_range(0, 99));
      s_ack = (r >= 2 && r < 56);
      s_err = (r >= 56 && r < 61);
      s_rty = (r >= 61 && r < 66);
      if (r < 2) hang = int'($urandom_range(6, 12));
    end
  endtask

  // Hard stop in case something keeps the bench from reaching its report.
  initial begin
    #2000000;
    $display("FAIL time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int m1_acks, m2_early, m2_done;
    logic [NM-1:0] prev_gnt;
    logic [NM-1:0] g;

    RST_I = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge CLK_I);
    #1;
    check_val("rst_s_cyc", S_CYC_O, 0);
    check_val("rst_s_stb", S_STB_O, 0);
    check_val("rst_gnt", GNT_O, 0);
    check_val("rst_tmo", TMO_O, 0);
    check_val("rst_m_dat", M_DAT_O, 0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    for (int k = 0; k < 3; k++) run_cycle();

    // Single write from M0.
    m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
    m_adr[0 +: AW] = 8'h04; m_dat[0 +: DW] = 32'hDEADBEEF; m_sel[0 +: SW] = 4'hF;
    #1 check_val("wr_gnt_latency", GNT_O, 4'b0000);
    run_cycle();
    s_ack = 1;
    #1;
    check_val("wr_gnt", GNT_O, 4'b0001);
    check_val("wr_adr", S_ADR_O, 8'h04);
    check_val("wr_dat", S_DAT_O, 32'hDEADBEEF);
    check_val("wr_ack", M_ACK_O, 4'b0001);
    run_cycle();
    m_cyc = '0; m_stb = '0;
    #1 check_val("wr_ack_once", M_ACK_O, 4'b0000);
    run_cycle();
    s_ack = 0;
    #1 check_val("wr_idle_gnt", GNT_O, 4'b0000);
    run_cycle();

    // All four masters doing back-to-back single reads: round-robin order.
    do_reset();
    for (int k = 0; k < 5; k++) exp_q.push_back(NM'(1) << (k % NM));
    m_cyc = '1; m_stb = '1; s_ack = 1; s_dat = 32'h12345678;
    prev_gnt = '0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (GNT_O != '0 && prev_gnt == '0 && exp_q.size() > 0) begin
        g = exp_q.pop_front();
        check_val("rr_order", GNT_O, g);
      end
      if (M_ACK_O != '0) check_val("rr_rdata", M_DAT_O, 32'h12345678);
      prev_gnt = GNT_O;
      run_cycle();
      for (int i = 0; i < NM; i++) begin
        if (!m_cyc[i]) begin
          m_cyc[i] = 1; m_stb[i] = 1;
        end else if (e_ack[i]) begin
          m_cyc[i] = 0; m_stb[i] = 0;
        end
      end
    end
    check_val("rr_all_granted", exp_q.size(), 0);

    // M1 4-beat block read while M2 waits.
    do_reset();
    m_cyc = 4'b0110; m_stb = 4'b0110; s_ack = 1;
    beats[1] = 4; m1_acks = 0; m2_early = 0; m2_done = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (M_ACK_O[1]) m1_acks++;
      if (m_cyc[1] && (GNT_O[2] || M_ACK_O[2])) m2_early++;
      if (M_ACK_O[2]) m2_done = 1;
      run_cycle();
      if (e_ack[1]) begin
        beats[1]--;
        if (beats[1] == 0) begin m_cyc[1] = 0; m_stb[1] = 0; end
      end
      if (e_ack[2]) begin m_cyc[2] = 0; m_stb[2] = 0; end
    end
    check_val("blk_m1_acks", m1_acks, 4);
    check_val("blk_m2_early", m2_early, 0);
    check_val("blk_m2_served", m2_done, 1);

    // Slave never answers: watchdog abort after TO strobe cycles.
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    for (int c = 0; c <= TO; c++) run_cycle();
    #1;
    check_val("wd_tmo", TMO_O, 1);
    check_val("wd_err", M_ERR_O, 4'b0100);
    check_val("wd_s_cyc", S_CYC_O, 0);
    run_cycle();
    s_ack = 1;
    #1;
    check_val("wd_tmo_pulse", TMO_O, 0);
    check_val("wd_err_pulse", M_ERR_O, 4'b0000);
    check_val("wd_abort_ack_drop", M_ACK_O, 4'b0000);
    run_cycle();
    s_ack = 0; m_cyc = '0; m_stb = '0;
    run_cycle();
    #1 check_val("wd_idle", GNT_O, 4'b0000);
    run_cycle();

    // Ack on the last allowed cycle completes normally.
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    for (int c = 0; c < TO; c++) run_cycle();
    s_ack = 1;
    #1 check_val("wd_edge_ack", M_ACK_O, 4'b0100);
    run_cycle();
    s_ack = 0; m_cyc = '0; m_stb = '0;
    #1;
    check_val("wd_edge_tmo", TMO_O, 0);
    check_val("wd_edge_gnt", GNT_O, 4'b0100);
    run_cycle();
    run_cycle();

    // Retry goes to the owner only and the grant is kept while CYC stays high.
    do_reset();
    m_cyc = 4'b1000; m_stb = 4'b1000; s_rty = 1;
    #1 check_val("rty_idle_drop", M_RTY_O, 4'b0000);
    run_cycle();
    m_cyc = 4'b1010; m_stb = 4'b1010;
    #1 check_val("rty_owner", M_RTY_O, 4'b1000);
    run_cycle();
    s_rty = 0; m_stb = 4'b0010;
    #1 check_val("rty_hold", GNT_O, 4'b1000);
    run_cycle();
    m_cyc = 4'b0010;
    run_cycle();
    run_cycle();

    // Reset in the middle of an owned transfer drops the slave cycle at once.
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    run_cycle();
    run_cycle();
    s_ack = 1;
    RST_I = 1'b1;
    #1;
    check_val("mid_rst_s_cyc", S_CYC_O, 0);
    check_val("mid_rst_s_stb", S_STB_O, 0);
    check_val("mid_rst_ack", M_ACK_O, 4'b0000);
    @(negedge CLK_I);
    RST_I = 1'b0;
    clear_inputs();
    model_reset();
    run_cycle();

    // Randomized traffic with stalls long enough to trip the watchdog.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      masters_step();
      slave_step();
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
